pedal_chain_sequencer: RTL and testbench

Per-sample scheduler for the pedal effect chain (overdrive, tremolo, vibrato, echo). It captures one input sample per codec strobe and walks the enabled stages strictly in order. For each enabled stage it issues a one-cycle start, waits for done, and feeds that stage's result into the next. It replaces the static bypass-mux chain and free-running start logic with a single FSM, so each stage sees exactly one start per sample and bypassed stages cost no processing.

---
 rtl/pedal_chain_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pedal_chain_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pedal_chain_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : pedal_chain_sequencer                                           |
// | Purpose  : Per-sample FSM that runs enabled effect stages strictly in order |
// | Option   : CHAIN_TIMEOUT_EN adds per-stage hang detection (stage_err).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pedal_chain_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         sample_strobe,
  input  logic [DATA_W-1:0]            Signal_in,
  input  logic [NUM_STAGES-1:0]        stage_en,
  output logic [DATA_W-1:0]            stage_in,
  output logic [NUM_STAGES-1:0]        stage_start,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_result,
  output logic [DATA_W-1:0]            Signal_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic [NUM_STAGES-1:0]        stage_err
);

  localparam int IDX_W = $clog2(NUM_STAGES + 1);
  localparam int SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] c_IDX_END = IDX_W'(NUM_STAGES);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_SCAN   = 3'd1;
  localparam logic [2:0] c_ST_ISSUE  = 3'd2;
  localparam logic [2:0] c_ST_WAIT   = 3'd3;
  localparam logic [2:0] c_ST_FINISH = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [IDX_W-1:0]      r_idx;
  logic [SEL_W-1:0]      w_sel;
  logic [DATA_W-1:0]     r_work;
  logic [DATA_W-1:0]     r_sig_out;
  logic [NUM_STAGES-1:0] r_en_lat;
  logic                  r_out_valid;
  logic                  r_overrun;
  logic [DATA_W-1:0]     w_res [NUM_STAGES];
  logic                  w_done;
  logic                  w_tmo;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("pedal_chain_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_unpack
    assign w_res[g] = stage_result[g*DATA_W +: DATA_W];
  end

  // idx only addresses a stage while below NUM_STAGES, so the low bits suffice
  assign w_sel  = r_idx[SEL_W-1:0];
  assign w_done = stage_done[w_sel];

`ifdef CHAIN_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] c_TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [TCNT_W-1:0]     r_tcnt;
  logic [NUM_STAGES-1:0] r_err;

  // done in the same cycle as the last count wins over the timeout
  assign w_tmo = (r_tcnt == c_TCNT_LAST) && !w_done;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_tcnt <= '0;
      r_err  <= '0;
    end else if (r_state == c_ST_ISSUE) begin
      r_tcnt <= '0;
    end else if (r_state == c_ST_WAIT) begin
      r_tcnt <= r_tcnt + 1'b1;
      if (w_tmo) r_err[w_sel] <= 1'b1;
    end
  end

  assign stage_err = r_err;
`else
  assign w_tmo     = 1'b0;
  assign stage_err = '0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= c_ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:   if (sample_strobe) w_next = c_ST_SCAN;
      c_ST_SCAN: begin
        if (r_idx == c_IDX_END)   w_next = c_ST_FINISH;
        else if (r_en_lat[w_sel]) w_next = c_ST_ISSUE;
      end
      c_ST_ISSUE:  w_next = c_ST_WAIT;
      c_ST_WAIT:   if (w_done || w_tmo) w_next = c_ST_SCAN;
      c_ST_FINISH: w_next = c_ST_IDLE;
      default:     w_next = c_ST_IDLE;
    endcase
  end

  // start is gated by Reset so an abort never leaks a pulse in the reset cycle
  always_comb begin
    stage_start = '0;
    busy        = (r_state != c_ST_IDLE);
    if ((r_state == c_ST_ISSUE) && !Reset) stage_start[w_sel] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_work      <= '0;
      r_en_lat    <= '0;
      r_idx       <= '0;
      r_sig_out   <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_overrun   <= sample_strobe && (r_state != c_ST_IDLE);
      case (r_state)
        c_ST_IDLE: begin
          if (sample_strobe) begin
            r_work   <= Signal_in;
            r_en_lat <= stage_en;
            r_idx    <= '0;
          end
        end
        c_ST_SCAN: begin
          if ((r_idx != c_IDX_END) && !r_en_lat[w_sel]) r_idx <= r_idx + 1'b1;
        end
        c_ST_WAIT: begin
          if (w_done) begin
            r_work <= w_res[w_sel];
            r_idx  <= r_idx + 1'b1;
          end else if (w_tmo) begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        c_ST_FINISH: begin
          r_sig_out   <= r_work;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stage_in   = r_work;
  assign Signal_out = r_sig_out;
  assign out_valid  = r_out_valid;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pedal_chain_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_pedal_chain_sequencer                                        |
// | Purpose  : Self-checking bench with emulated effect stages and a model.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pedal_chain_sequencer;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int TMO = 16;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              sample_strobe = 1'b0;
  logic [DW-1:0]     Signal_in = '0;
  logic [N-1:0]      stage_en = '0;
  logic [DW-1:0]     stage_in;
  logic [N-1:0]      stage_start;
  logic [N-1:0]      stage_done = '0;
  logic [N*DW-1:0]   stage_result;
  logic [DW-1:0]     Signal_out;
  logic              out_valid;
  logic              busy;
  logic              overrun;
  logic [N-1:0]      stage_err;

  pedal_chain_sequencer #(
    .NUM_STAGES(N), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .sample_strobe(sample_strobe), .Signal_in(Signal_in),
    .stage_en(stage_en), .stage_in(stage_in), .stage_start(stage_start),
    .stage_done(stage_done), .stage_result(stage_result), .Signal_out(Signal_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun), .stage_err(stage_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          stg;
    logic [15:0] din;
  } start_t;

  start_t      sq[$];
  start_t      exp_q[$];
  start_t      tmp_s;
  int          ovr_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          delay [N];
  int          cnt   [N];
  logic [15:0] res   [N];
  logic [15:0] cap   [N];
  bit          fixed_en  [N];
  logic [15:0] fixed_val [N];
  bit          level_mode = 1'b0;
  logic [15:0] exp_out;
  int          exp_lat;
  int          cyc0;
  logic [N-1:0] err_model = '0;
  int          ov_total = 0;
  int          ov_exp = 0;

  assign stage_result = {res[3], res[2], res[1], res[0]};

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stage behaviour: rotate left by one, then xor with a per-stage key
  function automatic logic [15:0] stage_fn(input int i, input logic [15:0] x);
    logic [15:0] key;
    if (fixed_en[i]) return fixed_val[i];
    case (i)
      0:       key = 16'h5A5A;
      1:       key = 16'h0F0F;
      2:       key = 16'hC3C3;
      default: key = 16'h1234;
    endcase
    return {x[14:0], x[15]} ^ key;
  endfunction

  // Emulated effect stages plus event logging
  initial begin
    forever begin
      @(negedge Clk);
      if (stage_start != '0) begin
        checks++;
        assert ($onehot(stage_start)) else begin
          errors++;
          $error("FAIL start_onehot observed %b expected one-hot", stage_start);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (stage_start[i]) begin
          tmp_s.stg = i;
          tmp_s.din = stage_in;
          sq.push_back(tmp_s);
          stage_done[i] = 1'b0;
          cnt[i] = delay[i];
          cap[i] = stage_in;
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            stage_done[i] = 1'b1;
            res[i] = stage_fn(i, cap[i]);
          end
        end else if (!level_mode && stage_done[i]) begin
          stage_done[i] = 1'b0;
        end
      end
      if (overrun)   ovr_q.push_back(cyc);
      if (out_valid) ov_total++;
    end
  end

  // Reference: the enabled stages compose in order; bypassed costs 1 cycle,
  // an enabled stage costs scan+issue+wait, a hung stage waits TMO cycles.
  task automatic launch(input logic [15:0] din, input logic [N-1:0] en);
    logic [15:0] w;
    start_t      e;
    w = din;
    exp_q.delete();
    exp_lat = N + 3;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        e.stg = i;
        e.din = w;
        exp_q.push_back(e);
        if (delay[i] == 0) begin
          exp_lat += 1 + TMO;
          err_model[i] = 1'b1;
        end else begin
          w = stage_fn(i, w);
          exp_lat += 1 + delay[i];
        end
      end
    end
    exp_out       = w;
    Signal_in     = din;
    stage_en      = en;
    sample_strobe = 1'b1;
    cyc0          = cyc;
    @(negedge Clk);
    sample_strobe = 1'b0;
    Signal_in     = 16'($urandom);
  endtask

  task automatic finish_check(input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge Clk);
      if (out_valid) got = 1'b1;
    end
    check({tag, "_valid_seen"}, 64'(got), 64'd1);
    if (got) begin
      ov_exp++;
      check({tag, "_latency"}, 64'(cyc - cyc0), 64'(exp_lat));
      check({tag, "_sig_out"}, 64'(Signal_out), 64'(exp_out));
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_stage_err"}, 64'(stage_err), 64'(err_model));
      check({tag, "_start_cnt"}, 64'(sq.size()), 64'(exp_q.size()));
      for (int j = 0; j < exp_q.size() && j < sq.size(); j++) begin
        check({tag, "_start_stage"}, 64'(sq[j].stg), 64'(exp_q[j].stg));
        check({tag, "_stage_in"}, 64'(sq[j].din), 64'(exp_q[j].din));
      end
    end
    sq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ocyc;
    bit  seen;
    for (int i = 0; i < N; i++) begin
      delay[i] = 2; cnt[i] = 0; res[i] = '0; cap[i] = '0;
      fixed_en[i] = 1'b0; fixed_val[i] = '0;
    end

    repeat (3) @(negedge Clk);
    check("rst_sig_out",   64'(Signal_out),  64'd0);
    check("rst_out_valid", 64'(out_valid),   64'd0);
    check("rst_busy",      64'(busy),        64'd0);
    check("rst_overrun",   64'(overrun),     64'd0);
    check("rst_stage_err", 64'(stage_err),   64'd0);
    check("rst_start",     64'(stage_start), 64'd0);
    check("rst_stage_in",  64'(stage_in),    64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // all bypassed
    launch(16'h1234, 4'b0000);
    finish_check("t1");

    // stages 0 and 2 with fixed results
    fixed_en[0] = 1'b1; fixed_val[0] = 16'h0100; delay[0] = 3;
    fixed_en[2] = 1'b1; fixed_val[2] = 16'h0200; delay[2] = 2;
    launch(16'hABCD, 4'b0101);
    finish_check("t2");
    fixed_en[0] = 1'b0; fixed_en[2] = 1'b0;

    // overrun while busy, then back-to-back idle strobe
    for (int i = 0; i < N; i++) delay[i] = 4;
    launch(16'h1111, 4'b1111);
    check("t3_busy", 64'(busy), 64'd1);
    sample_strobe = 1'b1;
    Signal_in     = 16'hDEAD;
    ocyc          = cyc;
    @(negedge Clk);
    sample_strobe = 1'b0;
    finish_check("t3");
    check("t3_ovr_cnt", 64'(ovr_q.size()), 64'd1);
    if (ovr_q.size() > 0) check("t3_ovr_cyc", 64'(ovr_q[0]), 64'(ocyc + 1));
    ovr_q.delete();
    launch(16'h2222, 4'b1111);
    finish_check("t3b");

    // enable change mid-sample applies only to the next sample
    launch(16'h4444, 4'b0001);
    @(negedge Clk);
    stage_en = 4'b1000;
    finish_check("t4a");
    launch(16'h5555, stage_en);
    finish_check("t4b");

`ifdef CHAIN_TIMEOUT_EN
    // stage 1 hangs and is skipped after the timeout
    delay[1] = 0;
    launch(16'h7FFF, 4'b0010);
    finish_check("t5");
    check("t5_err", 64'(stage_err), 64'h2);
    delay[1] = 2;
`endif

    // reset in the WAIT of stage 2
    for (int i = 0; i < N; i++) delay[i] = 3;
    level_mode = 1'b0;
    launch(16'h6666, 4'b1111);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge Clk);
      foreach (sq[j]) if (sq[j].stg == 2) seen = 1'b1;
    end
    check("t6_reached_s2", 64'(seen), 64'd1);
    @(negedge Clk);
    Reset = 1'b1;
    check("t6_start_in_rst", 64'(stage_start), 64'd0);
    @(negedge Clk);
    check("t6_busy",      64'(busy),        64'd0);
    check("t6_sig_out",   64'(Signal_out),  64'd0);
    check("t6_out_valid", 64'(out_valid),   64'd0);
    check("t6_overrun",   64'(overrun),     64'd0);
    check("t6_start",     64'(stage_start), 64'd0);
    check("t6_stage_in",  64'(stage_in),    64'd0);
    check("t6_stage_err", 64'(stage_err),   64'd0);
    Reset = 1'b0;
    err_model = '0;
    @(posedge Clk);
    #1;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      stage_done[i] = 1'b0;
    end
    sq.delete();
    ovr_q.delete();
    @(negedge Clk);
    launch(16'h0F0F, 4'b1010);
    finish_check("t6b");

    // randomized samples
    for (int r = 0; r < 24; r++) begin
      int gap;
      for (int i = 0; i < N; i++) delay[i] = int'($urandom_range(5, 1));
      level_mode = 1'($urandom);
      gap = int'($urandom_range(3, 0));
      repeat (gap) @(negedge Clk);
      launch(16'($urandom), 4'($urandom));
      finish_check("rnd");
    end

    @(negedge Clk);
    check("no_overrun",  64'(ovr_q.size()), 64'd0);
    check("valid_count", 64'(ov_total),     64'(ov_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
